// File: rtl/ifetch_pcgen.sv
// Instruction-fetch PC generator: holds the fetch PC, issues sequential word
// fetches on the icache ICB command channel, and applies flush/branch redirects.
module ifetch_pcgen #(
    parameter int            AW        = 32,
    parameter logic [AW-1:0] RESET_PC  = '0,
    parameter int            MAX_OUTST = 1,
    parameter int            CNT_W     = 2
) (
    input  logic          clk,
    input  logic          rst,
    output logic          icache_icb_cmd_valid,
    input  logic          icache_icb_cmd_ready,
    output logic          icache_icb_cmd_read,
    output logic [AW-1:0] icache_icb_cmd_addr,
    output logic [31:0]   icache_icb_cmd_wdata,
    output logic [3:0]    icache_icb_cmd_wmask,
    input  logic          icache_icb_rsp_valid,
    input  logic          icache_icb_rsp_ready,
    input  logic          flush,
    input  logic [AW-1:0] flush_pc,
    input  logic          branch,
    input  logic [AW-1:0] branch_pc,
    input  logic          halt,
    output logic [AW-1:0] pc_o
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTST);

    state_t           state;
    logic [AW-1:0]    pc;
    logic [CNT_W-1:0] outst;
    logic             pend;

    logic             rsp_hs;
    logic             redirect;
    logic [AW-1:0]    target;
    logic [CNT_W-1:0] outst_eff;
    logic             halt_now;
    logic             cmd_valid;
    logic             accept;

    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        rsp_hs    = icache_icb_rsp_valid & icache_icb_rsp_ready;
        redirect  = flush | branch;
        target    = flush ? flush_pc : branch_pc;
        // A returning beat frees its slot in the same cycle; never underflow on stray beats.
        outst_eff = outst - ((rsp_hs && (outst != '0)) ? CNT_W'(1) : '0);
        halt_now  = halt & ~pend;
        cmd_valid = (state == FETCH) && !redirect && !halt_now &&
                    ((outst_eff < MAX_C) || pend);
        accept    = cmd_valid & icache_icb_cmd_ready;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BOOT;
            pc    <= RESET_PC;
            outst <= '0;
            pend  <= 1'b0;
        end else begin
            pend <= cmd_valid & ~icache_icb_cmd_ready;
            if (redirect) begin
                // The downstream pipe is cleared by the same redirect, so nothing stays in flight.
                pc    <= target;
                outst <= '0;
                state <= halt ? HALT : FETCH;
            end else begin
                if (accept)
                    pc <= pc + AW'(4);
                outst <= outst_eff + CNT_W'(accept);
                case (state)
                    BOOT:    state <= halt ? HALT : FETCH;
                    FETCH:   if (halt && (!pend || accept)) state <= HALT;
                    HALT:    if (!halt) state <= FETCH;
                    default: state <= BOOT;
                endcase
            end
        end
    end

    assign icache_icb_cmd_valid = cmd_valid;
    assign icache_icb_cmd_addr  = pc;
    assign icache_icb_cmd_read  = 1'b1;
    assign icache_icb_cmd_wdata = '0;
    assign icache_icb_cmd_wmask = '0;
    assign pc_o                 = pc;

endmodule

// File: tb/tb_ifetch_pcgen.sv
// Directed bench for ifetch_pcgen: per-cycle stimulus rows plus a scoreboard
// monitor that checks every accepted fetch address and the in-flight limit.
module tb_ifetch_pcgen;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_read;
    logic [AW-1:0] cmd_addr;
    logic [31:0]   cmd_wdata;
    logic [3:0]    cmd_wmask;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          flush;
    logic [AW-1:0] flush_pc;
    logic          branch;
    logic [AW-1:0] branch_pc;
    logic          halt;
    logic [AW-1:0] pc_o;

    int errors = 0;
    int checks = 0;
    int row_idx = 0;
    logic [AW-1:0] exp_q[$];

    always #5 clk = ~clk;

    ifetch_pcgen #(
        .AW(AW), .RESET_PC(32'h0000_0000), .MAX_OUTST(1), .CNT_W(2)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .icache_icb_cmd_valid (cmd_valid),
        .icache_icb_cmd_ready (cmd_ready),
        .icache_icb_cmd_read  (cmd_read),
        .icache_icb_cmd_addr  (cmd_addr),
        .icache_icb_cmd_wdata (cmd_wdata),
        .icache_icb_cmd_wmask (cmd_wmask),
        .icache_icb_rsp_valid (rsp_valid),
        .icache_icb_rsp_ready (rsp_ready),
        .flush                (flush),
        .flush_pc             (flush_pc),
        .branch               (branch),
        .branch_pc            (branch_pc),
        .halt                 (halt),
        .pc_o                 (pc_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One stimulus row: drive inputs, check outputs mid-cycle, advance to the next edge.
    task automatic apply(input logic r, input logic rdy, input logic rrdy,
                         input logic fl, input logic [AW-1:0] flpc,
                         input logic br, input logic [AW-1:0] brpc,
                         input logic hlt, input logic ev, input logic [AW-1:0] epc);
        rst       = r;
        cmd_ready = rdy;
        rsp_ready = rrdy;
        flush     = fl;
        flush_pc  = flpc;
        branch    = br;
        branch_pc = brpc;
        halt      = hlt;
        @(negedge clk);
        check($sformatf("valid@row%0d", row_idx), {31'b0, cmd_valid}, {31'b0, ev});
        check($sformatf("pc_o@row%0d", row_idx), pc_o, epc);
        if (ev)
            check($sformatf("addr@row%0d", row_idx), cmd_addr, epc);
        row_idx++;
        @(posedge clk);
        #1;
    endtask

    // Monitor + responder: scoreboard on accepts, returns a response one cycle after each accept.
    initial begin : monitor
        int   model_outst;
        int   model_eff;
        logic acc, hs, redir, rst_s;
        model_outst = 0;
        rsp_valid   = 1'b0;
        forever begin
            @(negedge clk);
            acc   = cmd_valid & cmd_ready;
            hs    = rsp_valid & rsp_ready;
            redir = flush | branch;
            rst_s = rst;
            model_eff = model_outst - ((hs && model_outst > 0) ? 1 : 0);
            if (acc) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: accept of 0x%08h with empty queue", cmd_addr);
                end else begin
                    check("sb_addr", cmd_addr, exp_q.pop_front());
                end
                check("outst_limit", model_eff, 0);
            end
            model_outst = (rst_s || redir) ? 0 : model_eff + (acc ? 1 : 0);
            @(posedge clk);
            #1;
            if (rst_s || redir) begin
                rsp_valid = 1'b0;
            end else begin
                if (hs)  rsp_valid = 1'b0;
                if (acc) rsp_valid = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst = 1'b1; cmd_ready = 1'b1; rsp_ready = 1'b1;
        flush = 1'b0; flush_pc = '0; branch = 1'b0; branch_pc = '0; halt = 1'b0;

        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        exp_q.push_back(32'h0000_0008);
        exp_q.push_back(32'h0000_000C);
        exp_q.push_back(32'h0000_0100);
        exp_q.push_back(32'h0000_0200);
        exp_q.push_back(32'h0000_0300);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0000);

        @(posedge clk);
        #1;
        check("tie_read", {31'b0, cmd_read}, 32'd1);
        check("tie_wdata", cmd_wdata, 32'd0);
        check("tie_wmask", {28'b0, cmd_wmask}, 32'd0);

        //     rst rdy rrdy fl flush_pc      br branch_pc     hlt ev  pc/addr
        apply(1, 1, 1, 0, 32'h0,        0, 32'h0,       0, 0, 32'h0000_0000); // reset
        apply(0, 1, 1, 0, 32'h0,        0, 32'h0,       0, 0, 32'h0000_0000); // BOOT
        apply(0, 1, 1, 0, 32'h0,        0, 32'h0,       0, 1, 32'h0000_0000);
        apply(0, 1, 1, 0, 32'h0,        0, 32'h0,       0, 1, 32'h0000_0004);
        apply(0, 0, 1, 0, 32'h0,        0, 32'h0,       0, 1, 32'h0000_0008); // stall x3
        apply(0, 0, 1, 0, 32'h0,        0, 32'h0,       0, 1, 32'h0000_0008);
        apply(0, 0, 1, 0, 32'h0,        0, 32'h0,       0, 1, 32'h0000_0008);
        apply(0, 1, 1, 0, 32'h0,        0, 32'h0,       0, 1, 32'h0000_0008); // accept 0x8
        apply(0, 1, 1, 0, 32'h0,        0, 32'h0,       0, 1, 32'h0000_000C);
        apply(0, 1, 0, 0, 32'h0,        0, 32'h0,       0, 0, 32'h0000_0010); // rsp blocked
        apply(0, 1, 0, 0, 32'h0,        0, 32'h0,       0, 0, 32'h0000_0010);
        apply(0, 0, 1, 0, 32'h0,        0, 32'h0,       0, 1, 32'h0000_0010); // slot freed same cycle
        apply(0, 0, 1, 0, 32'h0,        1, 32'h100,     0, 0, 32'h0000_0010); // branch over pending
        apply(0, 1, 1, 0, 32'h0,        0, 32'h0,       0, 1, 32'h0000_0100);
        apply(0, 1, 1, 1, 32'h200,      1, 32'h100,     0, 0, 32'h0000_0104); // flush beats branch
        apply(0, 1, 1, 0, 32'h0,        0, 32'h0,       0, 1, 32'h0000_0200);
        apply(0, 1, 1, 0, 32'h0,        0, 32'h0,       1, 0, 32'h0000_0204); // halt
        apply(0, 1, 1, 0, 32'h0,        0, 32'h0,       1, 0, 32'h0000_0204);
        apply(0, 1, 1, 0, 32'h0,        1, 32'h300,     1, 0, 32'h0000_0204); // redirect while halted
        apply(0, 1, 1, 0, 32'h0,        0, 32'h0,       1, 0, 32'h0000_0300);
        apply(0, 1, 1, 0, 32'h0,        0, 32'h0,       0, 0, 32'h0000_0300); // leave HALT
        apply(0, 1, 1, 0, 32'h0,        0, 32'h0,       0, 1, 32'h0000_0300);
        apply(0, 1, 1, 1, 32'hFFFF_FFFC, 0, 32'h0,      0, 0, 32'h0000_0304);
        apply(0, 1, 1, 0, 32'h0,        0, 32'h0,       0, 1, 32'hFFFF_FFFC);
        apply(0, 1, 1, 0, 32'h0,        0, 32'h0,       0, 1, 32'h0000_0000); // wrapped
        apply(0, 0, 1, 0, 32'h0,        0, 32'h0,       0, 1, 32'h0000_0004);
        apply(1, 0, 1, 0, 32'h0,        0, 32'h0,       0, 1, 32'h0000_0004); // reset mid-pending
        apply(0, 1, 1, 0, 32'h0,        0, 32'h0,       0, 0, 32'h0000_0000); // BOOT again
        apply(0, 1, 1, 0, 32'h0,        0, 32'h0,       0, 1, 32'h0000_0000);
        apply(0, 0, 1, 0, 32'h0,        0, 32'h0,       0, 1, 32'h0000_0004);

        check("sb_drain", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
